// File: rtl/alu4_pkg.sv
// Shared opcode constants and flag bundle for the alu4 execution unit.
package alu4_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/alu4_comb.sv
// Combinational datapath of alu4: result and status flags from A/B/sel.
module alu4_comb
    import alu4_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] result,
    output flags_t           flags
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};

    always_comb begin
        result         = sum[MSB:0];
        flags.carry    = sum[WIDTH];
        flags.overflow = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
        case (sel)
            OP_SUB: begin
                // diff[WIDTH] is set exactly when A < B unsigned
                result         = diff[MSB:0];
                flags.carry    = diff[WIDTH];
                flags.overflow = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
            end
            OP_AND: begin
                result         = A & B;
                flags.carry    = 1'b0;
                flags.overflow = 1'b0;
            end
            OP_OR: begin
                result         = A | B;
                flags.carry    = 1'b0;
                flags.overflow = 1'b0;
            end
            OP_XOR: begin
                result         = A ^ B;
                flags.carry    = 1'b0;
                flags.overflow = 1'b0;
            end
            OP_NOT: begin
                result         = ~A;
                flags.carry    = 1'b0;
                flags.overflow = 1'b0;
            end
            OP_SHL: begin
                result         = {A[MSB-1:0], 1'b0};
                flags.carry    = A[MSB];
                flags.overflow = 1'b0;
            end
            OP_SHR: begin
                result         = {1'b0, A[MSB:1]};
                flags.carry    = A[0];
                flags.overflow = 1'b0;
            end
            default: ;
        endcase
        flags.zero     = (result == '0);
        flags.negative = result[MSB];
    end

endmodule

// File: rtl/alu4.sv
// Registered ALU: captures operands on in_valid, presents result and
// flags one cycle later.
module alu4
    import alu4_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    logic [WIDTH-1:0] next_result;
    flags_t           next_flags;
    flags_t           flags_q;

    alu4_comb #(.WIDTH(WIDTH)) u_comb (
        .A      (A),
        .B      (B),
        .sel    (sel),
        .result (next_result),
        .flags  (next_flags)
    );

    // Flags are registered alongside the result so zero reads 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            flags_q   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result  <= next_result;
                flags_q <= next_flags;
            end
        end
    end

    assign carry    = flags_q.carry;
    assign zero     = flags_q.zero;
    assign negative = flags_q.negative;
    assign overflow = flags_q.overflow;

endmodule

// File: tb/tb_alu4.sv
// Table-driven scoreboard bench for alu4.
module tb_alu4;
    import alu4_pkg::*;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] res;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] a_in = '0;
    logic [3:0] b_in = '0;
    logic [2:0] sel = '0;
    logic [3:0] result;
    logic       out_valid, carry, zero, negative, overflow;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic       exp_valid = 1'b0;
    logic [7:0] last = '0;
    vec_t       tbl[16];
    vec_t       idle;

    alu4 #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a_in),
        .B         (b_in),
        .sel       (sel),
        .result    (result),
        .out_valid (out_valid),
        .carry     (carry),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pack_vec(input vec_t t);
        return {t.res, t.c, t.z, t.n, t.v};
    endfunction

    function automatic logic [7:0] outs();
        return {result, carry, zero, negative, overflow};
    endfunction

    task automatic chk(input string name, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic sample();
        logic [7:0] e;
        chk("out_valid", {7'b0, out_valid}, {7'b0, exp_valid});
        if (exp_valid) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 8'd1, 8'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result_flags", outs(), e);
                last = e;
            end
        end else begin
            chk("hold", outs(), last);
        end
    endtask

    task automatic drive(input vec_t t, input logic v);
        in_valid = v;
        a_in = t.a;
        b_in = t.b;
        sel = t.op;
        if (v) exp_q.push_back(pack_vec(t));
        exp_valid = v;
    endtask

    task automatic cycle(input vec_t t, input logic v);
        @(negedge clk);
        sample();
        drive(t, v);
    endtask

    initial begin
        tbl[0]  = '{4'b0011, 4'b0001, OP_ADD, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{4'b0100, 4'b0001, OP_SUB, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{4'b0001, 4'b0010, OP_SUB, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{4'b1100, 4'b1010, OP_AND, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{4'b1100, 4'b1010, OP_OR,  4'b1110, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{4'b1010, 4'b0000, OP_XOR, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{4'b1010, 4'b0000, OP_NOT, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{4'b1111, 4'b0001, OP_ADD, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{4'b0111, 4'b0001, OP_ADD, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{4'b1001, 4'b0000, OP_SHL, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{4'b1001, 4'b0000, OP_SHR, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{4'b1000, 4'b0001, OP_SUB, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{4'b0101, 4'b0101, OP_SUB, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{4'b0101, 4'b1010, OP_AND, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{4'b0001, 4'b1111, OP_SHR, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{4'b0100, 4'b0110, OP_SHL, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0};
        idle    = '{4'b0000, 4'b0000, OP_ADD, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset held with live random stimulus
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a_in = 4'($urandom);
            b_in = 4'($urandom);
            sel = 3'($urandom);
            chk("rst_outs", outs(), 8'h00);
            chk("rst_valid", {7'b0, out_valid}, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(idle, 1'b0);
        last = 8'h00;
        cycle(idle, 1'b0);

        // Back-to-back through every table entry
        for (int i = 0; i < 16; i++) cycle(tbl[i], 1'b1);
        cycle(idle, 1'b0);
        cycle(idle, 1'b0);

        // Isolated captures separated by idle gaps
        for (int i = 0; i < 16; i += 3) begin
            cycle(tbl[i], 1'b1);
            cycle(idle, 1'b0);
        end
        cycle(idle, 1'b0);

        // Async reset between edges clears outputs at once
        cycle(tbl[8], 1'b1);
        @(posedge clk);
        #2;
        chk("pre_async", outs(), pack_vec(tbl[8]));
        rst_n = 1'b0;
        #1;
        chk("async_outs", outs(), 8'h00);
        chk("async_valid", {7'b0, out_valid}, 8'h00);
        exp_q.delete();

        // Capture pending at reset assertion is discarded
        @(negedge clk);
        rst_n = 1'b1;
        drive(tbl[9], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("pend_outs", outs(), 8'h00);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive(idle, 1'b0);
        last = 8'h00;
        cycle(tbl[1], 1'b1);
        cycle(idle, 1'b0);
        cycle(idle, 1'b0);

        if (exp_q.size() != 0) chk("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu4.md
Name: alu4

Overview:
- Registered 4-bit arithmetic/logic unit.
- Takes two operands and a 3-bit opcode, computes one of eight operations, and registers the result plus status flags one clock later.
- Sits in the datapath as a leaf execution unit; the result feeds a register file or bus.
- Operation codes are fixed below and shared via package.

Parameters:
- WIDTH, 4, operand/result width in bits (operations defined for any WIDTH>=2; default 4 is the verified configuration).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/sel valid this cycle; capture on rising clk
- A  input  WIDTH  operand A (unsigned; two's complement for overflow flag)
- B  input  WIDTH  operand B
- sel  input  3  operation select
- result  output  WIDTH  registered operation result
- out_valid  output  1  result/flags updated from an in_valid capture last cycle
- carry  output  1  carry-out (add), borrow (sub), shifted-out bit (shifts); 0 for logic ops
- zero  output  1  result == 0
- negative  output  1  result MSB
- overflow  output  1  signed overflow for add/sub; 0 otherwise

Behaviour:
- Reset: asynchronous on rst_n low. While rst_n is low, result=0, carry=0, zero=0, negative=0, overflow=0, out_valid=0. Release is synchronous to the next clk edge.
- Latency: exactly 1 cycle. Inputs are sampled on the rising clk with in_valid=1. Outputs appear after that edge, and out_valid=1 for that cycle.
- in_valid=0 at an edge: result and flags hold their previous values; out_valid=0.
- No backpressure. Back-to-back in_valid every cycle gives one result per cycle.
- sel encoding:
  - 000 ADD: A+B. Result truncated to WIDTH; carry = bit WIDTH.
  - 001 SUB: A-B modulo 2^WIDTH; carry = borrow (A<B unsigned).
  - 010 AND: A&B.
  - 011 OR: A|B.
  - 100 XOR: A^B.
  - 101 NOT: ~A (B ignored).
  - 110 SHL: A<<1, LSB filled with 0; carry = A[MSB].
  - 111 SHR: A>>1 logical, MSB filled with 0; carry = A[0].
- overflow:
  - ADD: A and B signs equal and result sign differs.
  - SUB: A and B signs differ and result sign differs from A.
- zero and negative are derived from the registered result itself.
- X/Z on sel while in_valid=1 is illegal. The implementation may treat it as ADD (default branch) and must not latch.
- Reset asserted mid-stream: the pending capture is discarded, and out_valid=0 on the first post-reset cycle.

Decomposition:
- Package alu4_pkg holds the sel opcode constants (OP_ADD..OP_SHR, 3-bit) and a flags struct {carry, zero, negative, overflow}.
- One combinational sub-module, alu4_comb, computes result and flags from A/B/sel.
- The top module adds the input-valid capture, output registers and reset.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> result=0, all flags 0, out_valid=0; release, no in_valid -> outputs unchanged.
- Arithmetic:
  - A=0011 B=0001 sel=000 -> result 0100, carry 0, zero 0, out_valid 1 one cycle later.
  - A=0100 B=0001 sel=001 -> 0011, borrow 0.
  - A=0001 B=0010 sel=001 -> 1111, carry 1, negative 1.
- Logic:
  - A=1100 B=1010 sel=010 -> 1000.
  - sel=011 -> 1110.
  - A=1010 B=0000 sel=100 -> 1010.
  - sel=101 -> 0101.
- Flags:
  - A=1111 B=0001 sel=000 -> 0000, carry 1, zero 1.
  - A=0111 B=0001 sel=000 -> 1000, overflow 1, negative 1.
- Shifts and pipelining:
  - A=1001 sel=110 -> 0010, carry 1.
  - A=1001 sel=111 -> 0100, carry 1.
  - Back-to-back in_valid over 8 opcodes -> one correct result per cycle.
  - in_valid=0 gap -> result holds, out_valid 0.
- Async reset mid-stream: assert rst_n between clock edges -> outputs clear immediately without waiting for clk.
